// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte write strobe and status bundle for the buffered UART transmitter.
// The master (CPU/probe side) drives the write strobe, data and overflow clear.
// The slave (transmitter) drives the serial line and the FIFO status.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
) ();
  logic                         uart_write;
  logic [7:0]                   uart_data;
  logic                         overflow_clr;
  logic                         tx;
  logic                         busy;
  logic                         full;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         overflow;

  modport master (
    output uart_write, uart_data, overflow_clr,
    input  tx, busy, full, level, overflow
  );

  modport slave (
    input  uart_write, uart_data, overflow_clr,
    output tx, busy, full, level, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB-first 8N1 frames.
// Writes never stall; a write to a full FIFO is dropped and flagged in sticky overflow.
// Optional even parity (8E1) is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 16
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [LvlW-1:0]  LvlFull  = LvlW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic       baud_done;
  logic       pop;
  logic       push;
  logic       drop;
  logic [7:0] head;

  assign baud_done = (baud_q == BaudLast);
  assign head      = mem_q[rd_ptr_q];

  // Transmit FSM: next state, shift/bit/baud counters and the registered tx value.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back frames have no idle gap.
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte captured at pop time.
  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = ^head;
  end
`endif

  // FIFO bookkeeping: a write to a full FIFO is still accepted if a pop frees a slot this cycle.
  always_comb begin
    push     = bus.uart_write && ((level_q != LvlFull) || pop);
    drop     = bus.uart_write && !push;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    // Set wins over clear when a drop coincides with overflow_clr.
    ovf_d = (ovf_q && !bus.overflow_clr) || drop;
  end

  // State registers; tx resets high so the line idles immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.uart_data;
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != StIdle) || (level_q != '0);
  assign bus.full     = (level_q == LvlFull);
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based frame model
// checked every cycle, plus literal expectations for selected frames and flags.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 4;
  localparam int unsigned DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FLEN = NBITS * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_fifo_if #(.DEPTH(DEP)) bus_if ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned mq[$];
  bit           m_active = 1'b0;
  int           m_t      = 0;
  logic [10:0]  m_frame  = '1;
  bit           m_ovf    = 1'b0;
  bit           m_pop;
  bit           m_drop;

  function automatic logic [10:0] build(input logic [7:0] b);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`else
    f[9]   = 1'b1;
`endif
    f[10]  = 1'b1;
    return f;
  endfunction

  function automatic logic m_tx();
    if (!m_active) return 1'b1;
    return m_frame[m_t / CPB];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_pop = (mq.size() > 0) && (!m_active || m_t == FLEN - 1);
      if (m_active) begin
        m_t++;
        if (m_t == FLEN) m_active = 1'b0;
      end
      if (m_pop) begin
        m_frame  = build(mq.pop_front());
        m_active = 1'b1;
        m_t      = 0;
      end
      m_drop = bus_if.uart_write && (mq.size() >= DEP);
      if (bus_if.uart_write && !m_drop) mq.push_back(bus_if.uart_data);
      if (bus_if.overflow_clr) m_ovf = 1'b0;
      if (m_drop) m_ovf = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("tx",       bus_if.tx,       m_tx());
      chk("busy",     bus_if.busy,     m_active || mq.size() != 0);
      chk("full",     bus_if.full,     mq.size() == DEP);
      chk("level",    bus_if.level,    mq.size());
      chk("overflow", bus_if.overflow, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [7:0] b);
    bus_if.uart_write = 1'b1;
    bus_if.uart_data  = b;
    @(negedge clk);
    bus_if.uart_write = 1'b0;
  endtask

  task automatic capture(input int n, output logic [43:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[i] = bus_if.tx;
    end
  endtask

  function automatic logic [43:0] expand(input logic [10:0] f);
    logic [43:0] e;
    e = '0;
    for (int i = 0; i < int'(FLEN); i++) e[i] = f[i / CPB];
    return e;
  endfunction

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus_if.busy) break;
    end
    chk(name, bus_if.busy, 1'b0);
  endtask

  logic [43:0] cap;
  logic [10:0] lit;
  bit          found;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.uart_write   = 1'b0;
    bus_if.uart_data    = 8'h00;
    bus_if.overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    bus_if.tx,       1'b1);
    chk("rst_busy",  bus_if.busy,     1'b0);
    chk("rst_level", bus_if.level,    0);
    chk("rst_ovf",   bus_if.overflow, 1'b0);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    // Single frame of 0x55.
    wr(8'h55);
    chk("w55_level", bus_if.level, 1);
    chk("w55_tx_still_high", bus_if.tx, 1'b1);
    capture(FLEN, cap);
`ifdef UART_TX_PARITY_EN
    lit = 11'b10010101010;
`else
    lit = 11'b01010101010;
`endif
    chk("frame55", cap, expand(lit));
    chk("busy_last_stop", bus_if.busy, 1'b1);
    @(negedge clk);
    chk("busy_after_stop", bus_if.busy, 1'b0);

    // Two back-to-back frames.
    repeat (2) @(negedge clk);
    wr(8'hA5);
    chk("b2b_level0", bus_if.level, 1);
    wr(8'h3C);
    chk("b2b_level1", bus_if.level, 1);
    @(negedge clk);
    chk("b2b_level2", bus_if.level, 1);
    repeat (FLEN - 2) @(negedge clk);
    chk("b2b_stop_tx", bus_if.tx, 1'b1);
    chk("b2b_stop_level", bus_if.level, 1);
    @(negedge clk);
    chk("b2b_start_tx", bus_if.tx, 1'b0);
    chk("b2b_start_level", bus_if.level, 0);
    drain("b2b_drain");

`ifdef UART_TX_PARITY_EN
    // Parity frames.
    @(negedge clk);
    wr(8'h07);
    capture(FLEN, cap);
    chk("frame07", cap, expand(11'b11000001110));
    chk("par07", cap[36], 1'b1);
    chk("len44_busy", bus_if.busy, 1'b1);
    @(negedge clk);
    chk("len44_idle", bus_if.busy, 1'b0);
    wr(8'h03);
    capture(FLEN, cap);
    chk("par03", cap[37], 1'b0);
    drain("par_drain");
`endif

    // Overflow: six writes on consecutive cycles from idle.
    @(negedge clk);
    for (int i = 1; i <= 6; i++) wr(8'(i * 8'h11));
    chk("ovf_full",  bus_if.full,     1'b1);
    chk("ovf_set",   bus_if.overflow, 1'b1);
    chk("ovf_level", bus_if.level,    DEP);
    bus_if.overflow_clr = 1'b1;
    @(negedge clk);
    bus_if.overflow_clr = 1'b0;
    chk("ovf_clr", bus_if.overflow, 1'b0);
    // Drop and clear together: set wins.
    bus_if.overflow_clr = 1'b1;
    wr(8'hEE);
    bus_if.overflow_clr = 1'b0;
    chk("ovf_set_wins", bus_if.overflow, 1'b1);
    chk("ovf_set_wins_level", bus_if.level, DEP);
    bus_if.overflow_clr = 1'b1;
    @(negedge clk);
    bus_if.overflow_clr = 1'b0;
    chk("ovf_clr2", bus_if.overflow, 1'b0);

    // Write while full exactly at the stop->start pop edge.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_active && m_t == FLEN - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pop_edge_found", found, 1'b1);
    wr(8'h77);
    chk("pop_write_level", bus_if.level,    DEP);
    chk("pop_write_ovf",   bus_if.overflow, 1'b0);
    chk("pop_write_tx",    bus_if.tx,       1'b0);
    drain("full_drain");

    // Reset in the middle of data bit 3 of 0x00.
    @(negedge clk);
    wr(8'h00);
    repeat (17) @(negedge clk);
    chk("pre_rst_tx", bus_if.tx, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",    bus_if.tx,    1'b1);
    chk("mid_rst_level", bus_if.level, 0);
    chk("mid_rst_busy",  bus_if.busy,  1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FLEN + 10) @(negedge clk);
    chk("post_rst_tx",   bus_if.tx,   1'b1);
    chk("post_rst_busy", bus_if.busy, 1'b0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
